ula_pipe: RTL and testbench

- Synchronous two-stage arithmetic/logic unit.
- Takes two DATA_WIDTH operands and a 3-bit opcode every clock.
- Returns a registered result, a carry/borrow flag and a valid flag.
- Sits behind ula_interface as the datapath under test; no input handshake, so every clock carries a new operation.

---
 rtl/ula_pkg.sv | 18 +
 rtl/ula_alu.sv | 30 +++
 rtl/ula_pipe.sv | 51 +++++
 tb/tb_ula_pipe.sv | 127 ++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: shared width, opcode encoding and result type for the ula datapath.
package ula_pkg;
   localparam int DATA_WIDTH = 8;
   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } ula_op_e;
   typedef struct packed {
      logic                  carry;
      logic [DATA_WIDTH-1:0] data;
   } ula_res_t;
endpackage

// File: rtl/ula_alu.sv
// ula_alu: combinational opcode decode and arithmetic; result is packed {carry, data}.
module ula_alu
   import ula_pkg::*;
(
   input  logic [2:0]            op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH:0]   res_o
);
   ula_res_t res;
   logic [DATA_WIDTH:0] sum, diff;
   // One extra bit on each operand turns its MSB into carry-out / borrow.
   assign sum  = {1'b0, a_i} + {1'b0, b_i};
   assign diff = {1'b0, a_i} - {1'b0, b_i};
   always_comb begin
      res = '0;
      case (ula_op_e'(op_i))
         OP_ADD: res = ula_res_t'(sum);
         OP_SUB: res = ula_res_t'(diff);
         OP_AND: res.data = a_i & b_i;
         OP_OR:  res.data = a_i | b_i;
         OP_XOR: res.data = a_i ^ b_i;
         OP_NOT: res.data = ~a_i;
         OP_SHL: res = ula_res_t'({a_i, 1'b0});
         OP_SHR: res = ula_res_t'({a_i[0], 1'b0, a_i[DATA_WIDTH-1:1]});
         default: res = '0;
      endcase
   end
   assign res_o = res;
endmodule

// File: rtl/ula_pipe.sv
// ula_pipe: two-stage ALU pipeline (input registers, ALU + output registers) with a
// valid shift register; rst is asynchronous and active-low.
module ula_pipe
   import ula_pkg::*;
#(
   parameter int DATA_WIDTH = ula_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            op_selector,
   input  logic [DATA_WIDTH-1:0] i_data_a,
   input  logic [DATA_WIDTH-1:0] i_data_b,
   output logic                  o_data_valid,
   output logic [DATA_WIDTH-1:0] o_data_result,
   output logic                  o_data_carryout
);
   logic [2:0]            op_q;
   logic [DATA_WIDTH-1:0] a_q, b_q;
   logic [1:0]            vld_q, vld_d;
   logic [DATA_WIDTH:0]   alu_res;
   ula_res_t              res_q, res_d;
   ula_alu u_alu (
      .op_i  (op_q),
      .a_i   (a_q),
      .b_i   (b_q),
      .res_o (alu_res)
   );
   // Outputs stay zero until stage 1 holds a genuinely sampled operation.
   always_comb begin
      vld_d = {vld_q[0], 1'b1};
      res_d = vld_q[0] ? ula_res_t'(alu_res) : '0;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         vld_q <= '0;
         res_q <= '0;
      end else begin
         op_q  <= op_selector;
         a_q   <= i_data_a;
         b_q   <= i_data_b;
         vld_q <= vld_d;
         res_q <= res_d;
      end
   end
   assign o_data_valid    = vld_q[1];
   assign o_data_result   = res_q.data;
   assign o_data_carryout = res_q.carry;
endmodule

// File: tb/tb_ula_pipe.sv
// tb_ula_pipe: table vectors, randomized ops against an arithmetic model, and reset corner cases.
module tb_ula_pipe;
   localparam int W = 8;
   logic clk = 1'b0, rst = 1'b0;
   logic [2:0] op;
   logic [W-1:0] a, b, res;
   logic vld, co;
   int n_chk = 0, n_fail = 0, idx = 0;
   logic [W:0] expq[$];
   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a, b, r;
      logic         c;
   } vec_t;
   vec_t tbl[14];

   always #5 clk = ~clk;

   ula_pipe #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .op_selector(op), .i_data_a(a), .i_data_b(b),
      .o_data_valid(vld), .o_data_result(res), .o_data_carryout(co)
   );

   function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int ux = int'(x), uy = int'(y), r = 0, c = 0;
      case (o)
         3'd0: begin r = (ux + uy) % 256; c = (ux + uy) / 256; end
         3'd1: begin r = (ux - uy + 256) % 256; c = (ux < uy) ? 1 : 0; end
         3'd2: r = int'(x & y);
         3'd3: r = int'(x | y);
         3'd4: r = int'(x ^ y);
         3'd5: r = 255 - ux;
         3'd6: begin r = (ux * 2) % 256; c = (ux >= 128) ? 1 : 0; end
         default: begin r = ux / 2; c = ux % 2; end
      endcase
      return {c[0], r[7:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (op #%0d): got %0h, required %0h", nm, idx, act, exp);
      end
   endtask

   // Called at a falling edge: checks the op issued two calls ago, then issues a new one.
   task automatic step(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W:0] e);
      if (expq.size() == 2) begin
         chk("valid", {31'd0, vld}, 32'd1);
         chk("result", {24'd0, res}, {24'd0, expq[0][W-1:0]});
         chk("carry", {31'd0, co}, {31'd0, expq[0][W]});
         void'(expq.pop_front());
      end else begin
         chk("prevalid valid", {31'd0, vld}, 32'd0);
         chk("prevalid result", {24'd0, res}, 32'd0);
         chk("prevalid carry", {31'd0, co}, 32'd0);
      end
      op = o; a = x; b = y;
      expq.push_back(e);
      idx++;
      @(negedge clk);
   endtask

   task automatic rnd_step(input bit add_only);
      logic [2:0] o;
      logic [W-1:0] x, y;
      o = add_only ? 3'd0 : 3'($urandom_range(0, 7));
      x = W'($urandom);
      y = W'($urandom);
      step(o, x, y, model(o, x, y));
   endtask

   initial begin
      tbl[0]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1};
      tbl[1]  = '{3'd0, 8'h12, 8'h34, 8'h46, 1'b0};
      tbl[2]  = '{3'd1, 8'h05, 8'h07, 8'hFE, 1'b1};
      tbl[3]  = '{3'd1, 8'h07, 8'h05, 8'h02, 1'b0};
      tbl[4]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0};
      tbl[5]  = '{3'd3, 8'hF0, 8'h3C, 8'hFC, 1'b0};
      tbl[6]  = '{3'd4, 8'hF0, 8'h3C, 8'hCC, 1'b0};
      tbl[7]  = '{3'd5, 8'hF0, 8'h3C, 8'h0F, 1'b0};
      tbl[8]  = '{3'd6, 8'h81, 8'h00, 8'h02, 1'b1};
      tbl[9]  = '{3'd7, 8'h81, 8'h00, 8'h40, 1'b1};
      tbl[10] = '{3'd6, 8'h7E, 8'h00, 8'hFC, 1'b0};
      tbl[11] = '{3'd7, 8'h7E, 8'h00, 8'h3F, 1'b0};
      tbl[12] = '{3'd0, 8'h80, 8'h80, 8'h00, 1'b1};
      tbl[13] = '{3'd1, 8'h00, 8'h00, 8'h00, 1'b0};

      // Reset held with random inputs: outputs must stay zero.
      rst = 1'b0;
      op = 3'($urandom); a = W'($urandom); b = W'($urandom);
      repeat (3) begin
         @(negedge clk);
         chk("reset valid", {31'd0, vld}, 32'd0);
         chk("reset result", {24'd0, res}, 32'd0);
         chk("reset carry", {31'd0, co}, 32'd0);
         op = 3'($urandom); a = W'($urandom); b = W'($urandom);
      end
      rst = 1'b1;
      expq.delete();

      for (int i = 0; i < 14; i++) step(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].c, tbl[i].r});
      for (int i = 0; i < 300; i++) rnd_step(1'b0);

      // Mid-stream reset between edges must clear outputs without a clock.
      for (int i = 0; i < 6; i++) rnd_step(1'b1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async valid", {31'd0, vld}, 32'd0);
      chk("async result", {24'd0, res}, 32'd0);
      chk("async carry", {31'd0, co}, 32'd0);
      @(negedge clk);
      chk("held valid", {31'd0, vld}, 32'd0);
      rst = 1'b1;
      expq.delete();
      step(3'd0, 8'hF0, 8'h20, {1'b1, 8'h10});
      for (int i = 0; i < 10; i++) rnd_step(1'b1);
      for (int i = 0; i < 40; i++) rnd_step(1'b0);
      rnd_step(1'b0);
      rnd_step(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
